// File: rtl/fifo_read_stream_if.sv
// Read-side stream bundle of the async FIFO: empty/increment handshake toward the
// read-pointer logic, RAM read data, and the valid/ready stream to the consumer.
// Optional macro: FIFO_RD_LEVEL_EN adds out_level (words buffered plus in flight).
interface fifo_read_stream_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BUF_DEPTH = 2
);

  logic              rempty;
  logic              rinc;
  logic [DATA_W-1:0] rdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

`ifdef FIFO_RD_LEVEL_EN
  localparam int unsigned LVL_W = $clog2(BUF_DEPTH) + 1;

  logic [LVL_W-1:0]  out_level;

  // Output stage side: consumes FIFO flags/data, produces the stream
  modport master (
    input  rempty, rdata, out_ready,
    output rinc, out_valid, out_data, out_level
  );

  // Environment side: FIFO/RAM and consumer
  modport slave (
    output rempty, rdata, out_ready,
    input  rinc, out_valid, out_data, out_level
  );
`else
  // Output stage side: consumes FIFO flags/data, produces the stream
  modport master (
    input  rempty, rdata, out_ready,
    output rinc, out_valid, out_data
  );

  // Environment side: FIFO/RAM and consumer
  modport slave (
    output rempty, rdata, out_ready,
    input  rinc, out_valid, out_data
  );
`endif

endinterface

// File: rtl/fifo_read_stream.sv
// fifo_read_stream: read-domain output stage of the async FIFO. Issues rinc while the
// FIFO is non-empty and skid-buffer credit exists, captures RAM read data one cycle
// later, and presents the buffered words as a registered valid/ready stream.
// Optional macro: FIFO_RD_LEVEL_EN adds out_level = buffered count + in-flight read.
module fifo_read_stream #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_read_stream_if.master bus
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              inflight_q;
  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [PTR_W-1:0]  head_nxt;
  logic [DATA_W-1:0] buf_q [BUF_DEPTH];
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] out_data_nxt;
  logic              pop;
  logic              rinc;
  logic [SUM_W-1:0]  occ_after_pop;

  // Credit check, next occupancy and the next head word (with same-cycle write bypass)
  always_comb begin
    pop           = out_valid_q & bus.out_ready;
    occ_after_pop = SUM_W'(count_q) + SUM_W'(inflight_q) - SUM_W'(pop);
    rinc          = rst_n & ~bus.rempty & (occ_after_pop < SUM_W'(BUF_DEPTH));
    count_nxt     = CNT_W'(occ_after_pop);
    head_nxt      = head_q + PTR_W'(pop);
    out_data_nxt  = buf_q[head_nxt];
    if (inflight_q && (tail_q == head_nxt)) begin
      out_data_nxt = bus.rdata;
    end
  end

  // Occupancy, in-flight marker, pointers and registered stream outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      inflight_q  <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      count_q     <= count_nxt;
      inflight_q  <= rinc;
      head_q      <= head_nxt;
      out_valid_q <= (count_nxt != '0);
      out_data_q  <= out_data_nxt;
      if (inflight_q) begin
        tail_q <= tail_q + PTR_W'(1);
      end
    end
  end

  // Skid-buffer storage; a RAM word lands here the cycle after its rinc
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (inflight_q) begin
      buf_q[tail_q] <= bus.rdata;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [CNT_W-1:0] level_q;

  // Level tracks count + inflight as they will stand next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= CNT_W'(SUM_W'(count_nxt) + SUM_W'(rinc));
    end
  end

  assign bus.out_level = level_q;
`endif

  assign bus.rinc      = rinc;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_fifo_read_stream.sv
// Directed bench for fifo_read_stream: a FIFO/RAM source model feeds words, a
// scoreboard queue holds the expected stream order, outputs sampled after negedge.
module tb_fifo_read_stream;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned BUF_DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fifo_read_stream_if #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) bus ();

  fifo_read_stream #(.DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Source FIFO model: words written by the stimulus, read by rinc with 1-cycle latency
  logic [DATA_W-1:0] src_mem [64];
  int                pushed     = 0;
  int                popped     = 0;
  logic              hold_empty = 1'b1;

  assign bus.rempty = hold_empty || (pushed == popped);

  always @(posedge clk) begin
    if (bus.rinc) begin
      bus.rdata <= src_mem[popped[5:0]];
      popped    <= popped + 1;
    end
  end

  int                n_chk    = 0;
  int                n_pass   = 0;
  int                rinc_cnt = 0;
  int                xfer_cnt = 0;
  logic [DATA_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    src_mem[pushed[5:0]] = w;
    pushed++;
    exp_q.push_back(w);
  endtask

  // Settle combinational outputs, then score any transfer in this cycle
  task automatic sample();
    #1;
    if (bus.rinc) begin
      rinc_cnt++;
      check("rinc_while_empty", 32'(bus.rempty), 32'd0);
    end
    if (bus.out_valid && bus.out_ready) begin
      xfer_cnt++;
      n_chk++;
      assert (exp_q.size() != 0) n_pass++;
      else $error("FAIL unexpected_word: observed 0x%0h expected none", bus.out_data);
      if (exp_q.size() != 0) check("out_data_order", 32'(bus.out_data), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic adv();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    sample();
    adv();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] rinc_tbl;
    logic [5:0] vld_tbl;
    bus.out_ready = 1'b0;
    bus.rdata     = '0;

    // Reset with the FIFO empty
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rinc", 32'(bus.rinc), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    check("rst_out_level", 32'(bus.out_level), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    sample();
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_rinc", 32'(bus.rinc), 32'd0);
    check("post_rst_out_data", 32'(bus.out_data), 32'd0);
    adv();

    // Three words streamed with the consumer always ready: no bubbles
    bus.out_ready = 1'b1;
    hold_empty    = 1'b0;
    push_word(8'hA1);
    push_word(8'hA2);
    push_word(8'hA3);
    rinc_tbl = 6'b000111;
    vld_tbl  = 6'b011100;
    for (int c = 0; c < 6; c++) begin
      sample();
      check($sformatf("s2_rinc_c%0d", c), 32'(bus.rinc), 32'(rinc_tbl[c]));
      check($sformatf("s2_valid_c%0d", c), 32'(bus.out_valid), 32'(vld_tbl[c]));
      adv();
    end
    check("s2_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure with five words queued: two reads, head word held
    bus.out_ready = 1'b0;
    rinc_cnt      = 0;
    push_word(8'hB1);
    push_word(8'hB2);
    push_word(8'hB3);
    push_word(8'hB4);
    push_word(8'hB5);
    for (int c = 0; c < 6; c++) begin
      sample();
`ifdef FIFO_RD_LEVEL_EN
      check($sformatf("s3_level_c%0d", c), 32'(bus.out_level), (c == 0) ? 32'd0 : (c == 1) ? 32'd1 : 32'd2);
`endif
      if (c >= 2) begin
        check($sformatf("s3_valid_c%0d", c), 32'(bus.out_valid), 32'd1);
        check($sformatf("s3_head_c%0d", c), 32'(bus.out_data), 32'hB1);
      end
      adv();
    end
    check("s3_rinc_pulses", 32'(rinc_cnt), 32'd2);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) cyc();
    check("s3_all_delivered", 32'(exp_q.size()), 32'd0);
    cyc();
    cyc();
    sample();
    check("s3_idle_valid", 32'(bus.out_valid), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
    check("s3_idle_level", 32'(bus.out_level), 32'd0);
`endif
    adv();

    // Single word with a toggling consumer: one read, one transfer
    rinc_cnt = 0;
    xfer_cnt = 0;
    push_word(8'hC7);
    for (int c = 0; c < 10; c++) begin
      bus.out_ready = (c % 2) == 1;
      cyc();
    end
    sample();
    check("s4_xfers", 32'(xfer_cnt), 32'd1);
    check("s4_rinc_pulses", 32'(rinc_cnt), 32'd1);
    check("s4_valid_end", 32'(bus.out_valid), 32'd0);
    adv();

    // Reset while a word is buffered and another read is in flight
    bus.out_ready = 1'b0;
    push_word(8'hD1);
    push_word(8'hD2);
    push_word(8'hD3);
    cyc();
    cyc();
    sample();
    check("s5_pre_valid", 32'(bus.out_valid), 32'd1);
`ifdef FIFO_RD_LEVEL_EN
    check("s5_pre_level", 32'(bus.out_level), 32'd2);
`endif
    hold_empty = 1'b1;
    rst_n      = 1'b0;
    #1;
    check("s5_async_valid", 32'(bus.out_valid), 32'd0);
    check("s5_async_rinc", 32'(bus.rinc), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      check($sformatf("s5_rel_valid_c%0d", c), 32'(bus.out_valid), 32'd0);
      check($sformatf("s5_rel_data_c%0d", c), 32'(bus.out_data), 32'd0);
      adv();
    end
    for (int i = popped; i < pushed; i++) exp_q.push_back(src_mem[i[5:0]]);
    xfer_cnt      = 0;
    hold_empty    = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) cyc();
    sample();
    check("s5_resume_xfers", 32'(xfer_cnt), 32'd1);
    check("s5_resume_drained", 32'(exp_q.size()), 32'd0);
    check("s5_resume_valid", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
